// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter and transfer sequencer for the shared snoop bus.
//   One requesting node is granted at a time. The source gets a one-cycle
//   processed_request pulse, the bus is then held for XFER_CYCLES cycles, and
//   the latched address is handed to the destination lane with a one-cycle
//   request_out_avail pulse. Destinations outside 0..NUM_PROC-1 are dropped
//   and flagged on bad_dest.
//
// Ports
//   clk_in             interconnect clock (divided)
//   rst_l              asynchronous active-low reset
//   request_in_avail   per-node request valid, held until acknowledged
//   addrs_in           per-node request address
//   request_dest       per-node destination node id
//   processed_request  one-hot accept pulse to the granted source
//   request_out_avail  one-hot delivery pulse to the destination
//   addrs_out          delivered address, only on the pulsed lane
//   bad_dest           pulse when a delivery is dropped for a bad destination
//   bus_busy           high while a transfer is in progress
//   grant_id           id of the current/last granted source
//   xfer_done_count    number of completed deliveries (wraps)
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int NUM_PROC    = 4,
   parameter int ADDR_W      = 48,
   parameter int XFER_CYCLES = 4
) (
   input  logic                                    clk_in,
   input  logic                                    rst_l,
   input  logic [NUM_PROC-1:0]                     request_in_avail,
   input  logic [NUM_PROC-1:0][ADDR_W-1:0]         addrs_in,
   input  logic [NUM_PROC-1:0][$clog2(NUM_PROC):0] request_dest,
   output logic [NUM_PROC-1:0]                     processed_request,
   output logic [NUM_PROC-1:0]                     request_out_avail,
   output logic [NUM_PROC-1:0][ADDR_W-1:0]         addrs_out,
   output logic                                    bad_dest,
   output logic                                    bus_busy,
   output logic [$clog2(NUM_PROC)-1:0]             grant_id,
   output logic [31:0]                             xfer_done_count
);

   localparam int PW = $clog2(NUM_PROC);
   localparam int DW = PW + 1;
   localparam int CW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;

   localparam logic [CW-1:0] CNT_INIT = CW'(XFER_CYCLES - 1);
   localparam logic [PW-1:0] LAST_ID  = PW'(NUM_PROC - 1);
   localparam logic [DW-1:0] NP_DEST  = DW'(NUM_PROC);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      XFER    = 2'd1,
      DELIVER = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]       grant_id_q;
   logic [31:0]         done_cnt_q;

   // Transaction payload; qualified by state, so it needs no reset.
   logic [PW-1:0]       src_q;
   logic [DW-1:0]       dest_q;
   logic [ADDR_W-1:0]   addr_q;

   logic                win_found;
   logic [PW-1:0]       win_id;
   logic                grant;
   logic                dest_ok;

   // Round-robin search: first set request bit starting at rr_ptr_q.
   always_comb begin
      int            idx;
      logic [PW-1:0] idx_w;
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      idx_w     = '0;
      for (int i = 0; i < NUM_PROC; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_PROC) begin
            idx = idx - NUM_PROC;
         end
         idx_w = idx[PW-1:0];
         if (!win_found && request_in_avail[idx_w]) begin
            win_found = 1'b1;
            win_id    = idx_w;
         end
      end
   end

   assign grant    = (state_q == IDLE) && win_found;
   assign rr_ptr_d = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
   assign dest_ok  = (dest_q < NP_DEST);

   // State / control registers
   always_ff @(posedge clk_in or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         done_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (grant) begin
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= win_id;
         end
         // Counted on the edge that enters DELIVER so it is visible with the pulse.
         if ((state_q == XFER) && (cnt_q == '0) && dest_ok) begin
            done_cnt_q <= done_cnt_q + 32'd1;
         end
      end
   end

   // Payload capture at grant
   always_ff @(posedge clk_in) begin
      if (grant) begin
         src_q  <= win_id;
         dest_q <= request_dest[win_id];
         addr_q <= addrs_in[win_id];
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = XFER;
               cnt_d   = CNT_INIT;
            end
         end
         XFER: begin
            if (cnt_q == '0) begin
               state_d = DELIVER;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DELIVER: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      processed_request = '0;
      request_out_avail = '0;
      addrs_out         = '0;
      bad_dest          = 1'b0;
      bus_busy          = (state_q != IDLE);
      // The counter holds its load value only in the first XFER cycle,
      // which is exactly the cycle after the grant edge.
      if ((state_q == XFER) && (cnt_q == CNT_INIT)) begin
         processed_request[src_q] = 1'b1;
      end
      if (state_q == DELIVER) begin
         if (dest_ok) begin
            request_out_avail[dest_q[PW-1:0]] = 1'b1;
            addrs_out[dest_q[PW-1:0]]         = addr_q;
         end else begin
            bad_dest = 1'b1;
         end
      end
   end

   assign grant_id        = grant_id_q;
   assign xfer_done_count = done_cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed and randomized stimulus for bus_arbiter. A transaction-level
//   model (grant age in cycles since the grant edge) predicts every output
//   each cycle; directed steps add fixed expectations from the test plan.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

   localparam int NP = 4;
   localparam int AW = 48;
   localparam int XC = 4;
   localparam int DW = $clog2(NP) + 1;

   logic                     clk;
   logic                     rst_l;

   logic [NP-1:0]            req;
   logic [NP-1:0][AW-1:0]    addrs;
   logic [NP-1:0][DW-1:0]    dests;
   logic [NP-1:0]            pr;
   logic [NP-1:0]            roa;
   logic [NP-1:0][AW-1:0]    ao;
   logic                     bd;
   logic                     bb;
   logic [DW-2:0]            gid;
   logic [31:0]              xcnt;

   logic [NP-1:0]            req1;
   logic [NP-1:0][AW-1:0]    addrs1;
   logic [NP-1:0][DW-1:0]    dests1;
   logic [NP-1:0]            pr1;
   logic [NP-1:0]            roa1;
   logic [NP-1:0][AW-1:0]    ao1;
   logic                     bd1;
   logic                     bb1;
   logic [DW-2:0]            gid1;
   logic [31:0]              xcnt1;

   bus_arbiter #(.NUM_PROC(NP), .ADDR_W(AW), .XFER_CYCLES(XC)) dut (
      .clk_in(clk), .rst_l(rst_l),
      .request_in_avail(req), .addrs_in(addrs), .request_dest(dests),
      .processed_request(pr), .request_out_avail(roa), .addrs_out(ao),
      .bad_dest(bd), .bus_busy(bb), .grant_id(gid), .xfer_done_count(xcnt)
   );

   bus_arbiter #(.NUM_PROC(NP), .ADDR_W(AW), .XFER_CYCLES(1)) dut1 (
      .clk_in(clk), .rst_l(rst_l),
      .request_in_avail(req1), .addrs_in(addrs1), .request_dest(dests1),
      .processed_request(pr1), .request_out_avail(roa1), .addrs_out(ao1),
      .bad_dest(bd1), .bus_busy(bb1), .grant_id(gid1), .xfer_done_count(xcnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int base  = 0;

   // reference model state
   bit          m_busy;
   int          m_age;
   int          m_src;
   int          m_dest;
   logic [47:0] m_addr;
   int          m_ptr;
   int          m_gid;
   logic [31:0] m_cnt;
   bit [NP-1:0] reraise;

   int obs_id[$];
   int obs_t[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc - base);
      end
   endtask

   function automatic logic [47:0] rand48();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[47:0];
   endfunction

   function automatic int onehot2id(input logic [NP-1:0] v);
      for (int i = 0; i < NP; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_age = 0; m_ptr = 0; m_gid = 0; m_cnt = '0;
   endtask

   // One clock edge as seen by the arbitration rules.
   task automatic model_update();
      if (m_busy) begin
         m_age++;
         if (m_age > XC) m_busy = 0;
         else if (m_age == XC && m_dest < NP) m_cnt = m_cnt + 32'd1;
      end else begin
         for (int i = 0; i < NP; i++) begin
            int j;
            j = (m_ptr + i) % NP;
            if (req[j]) begin
               m_busy = 1; m_age = 0;
               m_src = j; m_dest = int'(dests[j]); m_addr = addrs[j];
               m_ptr = (j + 1) % NP; m_gid = j;
               // node reacts to its ack: drop, or immediately post a new request
               if (reraise[j]) addrs[j] = rand48();
               else req[j] = 1'b0;
               break;
            end
         end
      end
   endtask

   task automatic check_model();
      logic [NP-1:0] e_pr, e_roa;
      logic          e_bd;
      e_pr = '0; e_roa = '0; e_bd = 1'b0;
      if (m_busy && m_age == 0) e_pr[m_src] = 1'b1;
      if (m_busy && m_age == XC) begin
         if (m_dest < NP) e_roa[m_dest] = 1'b1;
         else e_bd = 1'b1;
      end
      chk("processed_request", 64'(pr), 64'(e_pr));
      chk("request_out_avail", 64'(roa), 64'(e_roa));
      chk("bad_dest", 64'(bd), 64'(e_bd));
      chk("bus_busy", 64'(bb), 64'(m_busy));
      chk("grant_id", 64'(gid), 64'(m_gid));
      chk("xfer_done_count", 64'(xcnt), 64'(m_cnt));
      for (int i = 0; i < NP; i++)
         chk("addrs_out lane", 64'(ao[i]), e_roa[i] ? 64'(m_addr) : 64'd0);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (rst_l) model_update();
      check_model();
      if (pr != '0) begin
         obs_id.push_back(onehot2id(pr));
         obs_t.push_back(cyc - base);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      req = '0; reraise = '0;
      rst_l = 1'b0;
      model_reset();
      cycle();
      cycle();
      rst_l = 1'b1;
   endtask

   task automatic start_test();
      obs_id.delete();
      obs_t.delete();
      base = cyc + 1;
   endtask

   logic [31:0] cnt_before;

   initial begin
      rst_l = 1'b0;
      req = '0; addrs = '0; dests = '0; reraise = '0;
      req1 = '0; addrs1 = '0; dests1 = '0;
      model_reset();

      // reset state
      do_reset();
      chk("reset bus_busy", 64'(bb), 64'd0);
      chk("reset count", 64'(xcnt), 64'd0);

      // 1: single transfer node 1 -> node 2
      start_test();
      req[1] = 1'b1; dests[1] = 3'd2; addrs[1] = 48'h1234;
      cycle();
      chk("t1 ack", 64'(pr), 64'h2);
      run(3);
      chk("t1 busy c3", 64'(bb), 64'd1);
      cycle();
      chk("t1 deliver", 64'(roa), 64'h4);
      chk("t1 addr", 64'(ao[2]), 64'h1234);
      chk("t1 count", 64'(xcnt), 64'd1);
      cycle();
      chk("t1 idle", 64'(bb), 64'd0);
      chk("t1 no pulse", 64'(roa), 64'd0);

      // 4: bad destination
      start_test();
      cnt_before = m_cnt;
      req[2] = 1'b1; dests[2] = 3'd5; addrs[2] = 48'hABC;
      cycle();
      chk("t4 ack", 64'(pr), 64'h4);
      run(3);
      cycle();
      chk("t4 bad_dest", 64'(bd), 64'd1);
      chk("t4 no deliver", 64'(roa), 64'd0);
      chk("t4 count", 64'(xcnt), 64'(cnt_before));
      run(2);

      // 2: all four nodes request and hold
      do_reset();
      start_test();
      for (int i = 0; i < NP; i++) begin
         req[i] = 1'b1; dests[i] = DW'($urandom_range(0, NP - 1)); addrs[i] = rand48();
      end
      run(24);
      chk("t2 grants", 64'(obs_id.size()), 64'd4);
      for (int i = 0; i < obs_id.size() && i < 4; i++) begin
         chk("t2 grant order", 64'(obs_id[i]), 64'(i));
         chk("t2 grant cycle", 64'(obs_t[i]), 64'(6 * i));
      end
      chk("t2 count", 64'(xcnt), 64'd4);

      // 3: nodes 0 and 3 re-raise immediately
      do_reset();
      start_test();
      reraise[0] = 1'b1; reraise[3] = 1'b1;
      req = 4'b1001;
      dests[0] = 3'd1; dests[3] = 3'd2;
      addrs[0] = rand48(); addrs[3] = rand48();
      run(24);
      req = '0; reraise = '0;
      run(2);
      chk("t3 grants", 64'(obs_id.size()), 64'd4);
      for (int i = 0; i < obs_id.size() && i < 4; i++)
         chk("t3 grant order", 64'(obs_id[i]), (i % 2 == 0) ? 64'd0 : 64'd3);

      // 5: asynchronous reset mid-transfer
      do_reset();
      start_test();
      req[1] = 1'b1; dests[1] = 3'd0; addrs[1] = rand48();
      run(2);
      #2;
      rst_l = 1'b0;
      model_reset();
      #1;
      check_model();
      chk("t5 async busy", 64'(bb), 64'd0);
      chk("t5 async ack", 64'(pr), 64'd0);
      req = '0;
      run(2);
      rst_l = 1'b1;
      req[0] = 1'b1; req[2] = 1'b1;
      dests[0] = 3'd3; dests[2] = 3'd1;
      addrs[0] = rand48(); addrs[2] = rand48();
      start_test();
      cycle();
      chk("t5 first grant", 64'(pr), 64'h1);
      run(13);
      chk("t5 count", 64'(xcnt), 64'd2);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         cycle();
         for (int i = 0; i < NP; i++) begin
            if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i]   = 1'b1;
               addrs[i] = rand48();
               dests[i] = ($urandom_range(0, 9) < 8) ? DW'($urandom_range(0, NP - 1))
                                                     : DW'($urandom_range(NP, 7));
            end
         end
      end
      req = '0;
      run(8);

      // 6: single-cycle transfer instance
      start_test();
      req1[3] = 1'b1; dests1[3] = 3'd3; addrs1[3] = 48'h1;
      cycle();
      chk("t6 ack", 64'(pr1), 64'h8);
      chk("t6 busy", 64'(bb1), 64'd1);
      cycle();
      chk("t6 deliver", 64'(roa1), 64'h8);
      chk("t6 addr", 64'(ao1[3]), 64'h1);
      chk("t6 count", 64'(xcnt1), 64'd1);
      chk("t6 no ack", 64'(pr1), 64'd0);
      cycle();
      chk("t6 idle", 64'(bb1), 64'd0);
      chk("t6 no early grant", 64'(pr1), 64'd0);
      cycle();
      chk("t6 regrant", 64'(pr1), 64'h8);
      req1 = '0;
      run(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
